// File: rtl/ret_addr_stack_pkg.sv
// Shared constants and helpers for the return-address stack.
// Exports: RAS_AW, RAS_DEPTH and cnt_w(), the occupancy counter width.
package ret_addr_stack_pkg;

    localparam int RAS_AW    = 8;
    localparam int RAS_DEPTH = 8;

    // One extra bit so the counter can represent "full" (== DEPTH).
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// CALL/RET strobe and status bundle for the return-address stack.
// master: control unit (drives strobes); slave: the stack itself.
interface ret_addr_stack_if
    import ret_addr_stack_pkg::*;
#(
    parameter int AW = RAS_AW,
    parameter int CW = cnt_w(RAS_DEPTH)
);
    logic          push;
    logic          pop;
    logic [AW-1:0] ip_in;
    logic          clear_err;
    logic [AW-1:0] ret_addr;
    logic          ret_valid;
    logic [AW-1:0] top_addr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, pop, ip_in, clear_err,
        input  ret_addr, ret_valid, top_addr, count,
        input  full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, ip_in, clear_err,
        output ret_addr, ret_valid, top_addr, count,
        output full, empty, overflow, underflow
    );
endinterface

// File: rtl/ras_regfile.sv
// DEPTH x AW storage: one synchronous write port, one async read port.
// Ports: clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
module ras_regfile #(
    parameter int DEPTH = 8,
    parameter int AW    = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  logic [AW-1:0] i_wdata,
    input  logic [PW-1:0] i_raddr,
    output logic [AW-1:0] o_rdata
);
    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ret_addr_stack.sv
// Return-address LIFO: CALL pushes ip_in+1, RET pops into ret_addr.
// Ports: clk, rst (sync, active-high), bus (ret_addr_stack_if.slave).
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW
) (
    input  logic             clk,
    input  logic             rst,
    ret_addr_stack_if.slave  bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_ret_addr;
    logic          r_ret_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_do_pop;
    logic          w_we;
    logic          w_of_set;
    logic          w_uf_set;
    logic [PW-1:0] w_rd_idx;
    logic [PW-1:0] w_wr_idx;
    logic [AW-1:0] w_wdata;
    logic [AW-1:0] w_rd_data;

    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_do_pop = bus.pop && !w_empty;

    // A simultaneous accepted pop frees the top slot, so a push
    // is legal even when full; it then overwrites that slot.
    assign w_we     = bus.push && (!w_full || w_do_pop);
    assign w_of_set = bus.push && w_full && !w_do_pop;
    assign w_uf_set = bus.pop && w_empty;

    assign w_rd_idx = PW'(r_count - 1'b1);
    assign w_wr_idx = w_do_pop ? w_rd_idx : PW'(r_count);
    assign w_wdata  = bus.ip_in + AW'(1);

    ras_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_wr_idx),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ret_valid <= w_do_pop;
            if (w_do_pop) begin
                r_ret_addr <= w_rd_data;
            end

            if (w_we && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_we) begin
                r_count <= r_count - 1'b1;
            end

            // Setting an error wins over a same-cycle clear.
            if (w_of_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_err) begin
                r_overflow <= 1'b0;
            end

            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end else if (bus.clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.ret_addr  = r_ret_addr;
    assign bus.ret_valid = r_ret_valid;
    assign bus.top_addr  = w_empty ? '0 : w_rd_data;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_ret_addr_stack.sv
// Scoreboard bench for ret_addr_stack: directed plan plus random traffic.
// Model is a plain queue; a negedge monitor pops expectations.
module tb_ret_addr_stack;
    import ret_addr_stack_pkg::*;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [3:0] cnt;
        logic [7:0] top;
        logic       full;
        logic       empty;
        logic       of;
        logic       uf;
        logic       rv;
        logic [7:0] ra;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ret_addr_stack_if #(.AW(8), .CW(4)) bus ();

    ret_addr_stack #(.DEPTH(DEPTH), .AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0] stk [$];
    logic [7:0] rq  [$];
    st_t        sq  [$];
    logic       m_of = 1'b0;
    logic       m_uf = 1'b0;
    logic [7:0] m_ra = 8'h00;

    task automatic model(input logic p, input logic q,
                         input logic [7:0] ip, input logic c,
                         input logic r);
        st_t e;
        logic pop_ok;
        logic of_set;
        logic uf_set;
        pop_ok = 1'b0;
        of_set = 1'b0;
        uf_set = 1'b0;
        if (r) begin
            stk.delete();
            m_of = 1'b0;
            m_uf = 1'b0;
            m_ra = 8'h00;
        end else begin
            if (q) begin
                if (stk.size() > 0) begin
                    pop_ok = 1'b1;
                    m_ra = stk.pop_back();
                    rq.push_back(m_ra);
                end else begin
                    uf_set = 1'b1;
                end
            end
            if (p) begin
                if (stk.size() < DEPTH) stk.push_back(ip + 8'd1);
                else of_set = 1'b1;
            end
            if (of_set) m_of = 1'b1;
            else if (c) m_of = 1'b0;
            if (uf_set) m_uf = 1'b1;
            else if (c) m_uf = 1'b0;
        end
        e.cnt   = 4'(stk.size());
        e.top   = (stk.size() > 0) ? stk[$] : 8'h00;
        e.full  = (stk.size() == DEPTH);
        e.empty = (stk.size() == 0);
        e.of    = m_of;
        e.uf    = m_uf;
        e.rv    = pop_ok;
        e.ra    = m_ra;
        sq.push_back(e);
    endtask

    task automatic step(input logic p, input logic q,
                        input logic [7:0] ip, input logic c,
                        input logic r);
        bus.push      = p;
        bus.pop       = q;
        bus.ip_in     = ip;
        bus.clear_err = c;
        rst           = r;
        @(posedge clk);
        #1;
        model(p, q, ip, c, r);
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.clear_err = 1'b0;
        rst           = 1'b0;
    endtask

    always @(negedge clk) begin
        st_t e;
        st_t a;
        logic [7:0] x;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            a = '{bus.count, bus.top_addr, bus.full, bus.empty,
                  bus.overflow, bus.underflow, bus.ret_valid,
                  bus.ret_addr};
            checks++;
            if (a === e) passes++;
            else $display("FAIL status @%0t got %h want %h", $time, a, e);
        end
        if (bus.ret_valid === 1'b1) begin
            checks++;
            if (rq.size() == 0) begin
                $display("FAIL ret unexpected @%0t got %h", $time,
                         bus.ret_addr);
            end else begin
                x = rq.pop_front();
                if (bus.ret_addr === x) passes++;
                else $display("FAIL ret @%0t got %h want %h", $time,
                              bus.ret_addr, x);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.ip_in     = 8'h00;
        bus.clear_err = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 8'h00, 0, 1);
        step(1, 0, 8'h10, 0, 0);
        step(1, 0, 8'h20, 0, 0);
        step(1, 0, 8'h30, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
        step(1, 0, 8'h55, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(1, 1, 8'h07, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        for (int i = 1; i < DEPTH; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
        step(1, 1, 8'hFF, 0, 0);
        step(1, 0, 8'h11, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < DEPTH - 2; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 45,
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rq.size() == 0 && sq.size() == 0) passes++;
        else $display("FAIL drain ret=%0d status=%0d pending",
                      rq.size(), sq.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Hardware return-address stack for the 8-bit core.
- Sits beside the instruction-pointer register:
  - on CALL it captures the current IP + 1;
  - on RET it returns the saved address, which the control unit steers into the IP register's parallel-load path.
- Write side = CALL; read side = RET; LIFO with full/empty status and sticky error flags.

Parameters:
- DEPTH, 8, number of stored return addresses (power of two, 2..64)
- AW, 8, address width; must equal the IP register width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- push  input  1  CALL strobe; store ip_in + 1
- pop  input  1  RET strobe; remove top entry
- ip_in  input  AW  current IP value
- clear_err  input  1  clears overflow/underflow flags
- ret_addr  output  AW  registered popped address
- ret_valid  output  1  one-cycle pulse, ret_addr updated this cycle
- top_addr  output  AW  combinational view of top entry (0 when empty)
- count  output  $clog2(DEPTH)+1  current occupancy
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky, push refused while full
- underflow  output  1  sticky, pop refused while empty

Behaviour:
- Reset, synchronous, active-high. Applies on a rising edge with rst=1 and overrides every other input in that cycle:
  - count=0, ret_addr=0, ret_valid=0, overflow=0, underflow=0;
  - storage contents are don't-care; top_addr=0.
- Push only (push=1, pop=0):
  - not full: entry[count] <= (ip_in + 1) mod 2^AW; count+1. ip_in=8'hFF stores 8'h00.
  - full: no write, count unchanged, overflow <= 1.
- Pop only (pop=1, push=0):
  - not empty: ret_addr <= entry[count-1]; ret_valid=1 next cycle for exactly one cycle; count-1.
  - empty: ret_addr unchanged, ret_valid=0, underflow <= 1.
- Push and pop in the same cycle:
  - not empty: ret_addr <= old top; ret_valid pulses; top slot overwritten with ip_in + 1; count unchanged. This holds when full too, with no overflow.
  - empty: underflow <= 1; no ret_valid; push proceeds, so count=1.
- Latency: pop to ret_addr/ret_valid is 1 cycle. Push is visible on top_addr/count 1 cycle after the strobe edge.
- ret_valid is 0 in every cycle not following an accepted pop.
- clear_err=1 clears both sticky flags at the next edge. Set beats clear if an error occurs in the same cycle.
- full/empty are derived combinationally from count. No wrap-around: count saturates by refusal, never rolls over.
- Reset mid-sequence: any in-flight ret_valid is dropped the cycle after reset is sampled.

Decomposition:
- Shared package holds:
  - AW default (8), matching the IP register;
  - RAS_DEPTH default;
  - the count-width function.
- One natural sub-module: ras_regfile. It is a DEPTH x AW storage array with one synchronous write port and one asynchronous read port. The control and pointer logic stays in ret_addr_stack.

Test Plan:
- Reset then push with ip_in=8'h10, 8'h20, 8'h30 -> count=3, top_addr=8'h31, empty=0, full=0.
- Three pops after that -> ret_addr sequence 8'h31, 8'h21, 8'h11, each with a single-cycle ret_valid; then empty=1, top_addr=0.
- Push DEPTH=8 times, then a 9th push with ip_in=8'h55 -> full=1, count=8, overflow=1, top unchanged. clear_err -> overflow=0.
- Pop when empty -> underflow=1, ret_valid=0, ret_addr holds its previous value. Push+pop while empty with ip_in=8'h07 -> underflow=1, count=1, top_addr=8'h08.
- Full stack, push+pop with ip_in=8'hFF -> ret_addr = old top, ret_valid=1, top_addr=8'h00, count=8, overflow=0.
- rst asserted on the same edge as a pop from count=2 -> count=0, ret_valid=0 on the next cycle, flags cleared.
